// File: rtl/alu_ctl_pkg.sv
// rtl/alu_ctl_pkg.sv - ALUCtl operation codes shared by the ALU control decoder and the execute unit
package alu_ctl_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100,
        ALU_ERR = 4'b1111
    } alu_ctl_e;

    function automatic logic alu_ctl_legal(input logic [3:0] code);
        return (code == ALU_AND) || (code == ALU_OR)  || (code == ALU_ADD) ||
               (code == ALU_SUB) || (code == ALU_SLT) || (code == ALU_NOR);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - operand/result handshake bundle of the execute ALU (Overflow under ALU_OVERFLOW_EN)
interface alu_exec_unit_if #(
    parameter int WIDTH    = 32,
    parameter int ERRCNT_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          ALUCtl;
    logic [WIDTH-1:0]    A;
    logic [WIDTH-1:0]    B;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    Result;
    logic                Zero;
    logic                Illegal;
`ifdef ALU_OVERFLOW_EN
    logic                Overflow;
`endif
    logic [ERRCNT_W-1:0] ErrCount;

    modport slave (
        input  in_valid, ALUCtl, A, B, out_ready,
        output in_ready, out_valid, Result, Zero, Illegal,
`ifdef ALU_OVERFLOW_EN
        output Overflow,
`endif
        output ErrCount
    );

    modport master (
        output in_valid, ALUCtl, A, B, out_ready,
        input  in_ready, out_valid, Result, Zero, Illegal,
`ifdef ALU_OVERFLOW_EN
        input  Overflow,
`endif
        input  ErrCount
    );

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU operation and flag computation (Overflow under ALU_OVERFLOW_EN)
module alu_core
    import alu_ctl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
`ifdef ALU_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             illegal
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt_signed;

    assign sum       = a + b;
    assign diff      = a - b;
    // Direct signed compare stays correct when a - b overflows.
    assign lt_signed = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        case (alu_ctl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = sum;
            ALU_SUB: result = diff;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt_signed};
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

    assign illegal = !alu_ctl_legal(alu_ctl);
    assign zero    = !illegal && (result == '0);

`ifdef ALU_OVERFLOW_EN
    always_comb begin
        overflow = 1'b0;
        if (alu_ctl == ALU_ADD) begin
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else if (alu_ctl == ALU_SUB) begin
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
    end
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshake, output register and saturating illegal-code counter (ALU_OVERFLOW_EN adds Overflow)
module alu_exec_unit
    import alu_ctl_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ERRCNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    alu_exec_unit_if.slave bus
);

    logic [WIDTH-1:0]    core_result;
    logic                core_zero;
    logic                core_illegal;
    logic                in_ready;
    logic                accept;

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    result_q,    result_d;
    logic                zero_q,      zero_d;
    logic                illegal_q,   illegal_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;
`ifdef ALU_OVERFLOW_EN
    logic                core_overflow;
    logic                overflow_q,  overflow_d;
`endif

    alu_core #(.WIDTH(WIDTH)) u_core (
        .alu_ctl  (bus.ALUCtl),
        .a        (bus.A),
        .b        (bus.B),
        .result   (core_result),
        .zero     (core_zero),
`ifdef ALU_OVERFLOW_EN
        .overflow (core_overflow),
`endif
        .illegal  (core_illegal)
    );

    // A held result blocks new input until it drains; reset also blocks it.
    assign in_ready = rst_n && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        err_count_d = err_count_q;
`ifdef ALU_OVERFLOW_EN
        overflow_d  = overflow_q;
`endif
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = core_result;
            zero_d      = core_zero;
            illegal_d   = core_illegal;
`ifdef ALU_OVERFLOW_EN
            overflow_d  = core_overflow;
`endif
            if (core_illegal && (err_count_q != '1)) begin
                err_count_d = err_count_q + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            err_count_q <= '0;
`ifdef ALU_OVERFLOW_EN
            overflow_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            err_count_q <= err_count_d;
`ifdef ALU_OVERFLOW_EN
            overflow_q  <= overflow_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.Zero      = zero_q;
    assign bus.Illegal   = illegal_q;
    assign bus.ErrCount  = err_count_q;
`ifdef ALU_OVERFLOW_EN
    assign bus.Overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit with a random and directed operand stream
module tb_alu_exec_unit;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] r;
        bit           z;
        bit           ill;
        bit           ov;
        int           errs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   illegal_total = 0;
    bit   rand_ready = 1'b0;
    exp_t sb[$];

    alu_exec_unit_if #(.WIDTH(W), .ERRCNT_W(8)) bus ();
    alu_exec_unit_if #(.WIDTH(W), .ERRCNT_W(2)) bus2 ();

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.ALUCtl    = bus.ALUCtl;
    assign bus2.A         = bus.A;
    assign bus2.B         = bus.B;
    assign bus2.out_ready = bus.out_ready;

    alu_exec_unit #(.WIDTH(W), .ERRCNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_exec_unit #(.WIDTH(W), .ERRCNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb_v, s;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        e.r = '0; e.ill = 1'b0; e.ov = 1'b0; e.errs = 0;
        case (c)
            4'd0:  e.r = a & b;
            4'd1:  e.r = a | b;
            4'd2:  begin s = sa + sb_v; e.r = W'(s); e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd6:  begin s = sa - sb_v; e.r = W'(s); e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd7:  e.r = (sa < sb_v) ? 1 : 0;
            4'd12: e.r = ~(a | b);
            default: e.ill = 1'b1;
        endcase
        e.z = !e.ill && (e.r == 0);
        return e;
    endfunction

    // Monitor: pops on every output handshake, verifies held outputs, pushes on every accept.
    initial begin : monitor
        bit   prev_rst = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!prev_rst) begin
                sb.delete();
                illegal_total = 0;
                check("rst_out_valid", bus.out_valid, 0);
                check("rst_result", bus.Result, 0);
                check("rst_zero", bus.Zero, 0);
                check("rst_illegal", bus.Illegal, 0);
                check("rst_errcount", bus.ErrCount, 0);
                check("rst_errcount_w2", bus2.ErrCount, 0);
`ifdef ALU_OVERFLOW_EN
                check("rst_overflow", bus.Overflow, 0);
`endif
            end else if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb[0];
                    check("result", bus.Result, e.r);
                    check("zero", bus.Zero, e.z);
                    check("illegal", bus.Illegal, e.ill);
                    check("errcount", bus.ErrCount, (e.errs > 255) ? 255 : e.errs);
                    check("errcount_w2", bus2.ErrCount, (e.errs > 3) ? 3 : e.errs);
                    check("result_w2", bus2.Result, e.r);
`ifdef ALU_OVERFLOW_EN
                    check("overflow", bus.Overflow, e.ov);
`endif
                    if (bus.out_ready && rst_n) void'(sb.pop_front());
                end
            end
            if (rst_n) begin
                check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
                if (bus.in_valid && bus.in_ready) begin
                    e = model(bus.ALUCtl, bus.A, bus.B);
                    if (e.ill) illegal_total++;
                    e.errs = illegal_total;
                    sb.push_back(e);
                end
            end else begin
                check("in_ready_in_reset", bus.in_ready, 0);
            end
            prev_rst = rst_n;
        end
    end

    task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        bus.in_valid = 1'b1;
        bus.ALUCtl   = c;
        bus.A        = a;
        bus.B        = b;
        for (int i = 0; i < 64; i++) begin
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        failures++;
        $display("FAIL send_timeout actual=no_accept required=accept at %0t", $time);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [3:0] pick_ctl();
        logic [3:0] legal [6];
        legal = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        if ($urandom_range(0, 4) == 0) return 4'($urandom);
        return legal[$urandom_range(0, 5)];
    endfunction

    initial begin : driver
        bus.in_valid  = 1'b0;
        bus.ALUCtl    = 4'd0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        drain();

        send(4'd2, 32'h7FFF_FFFF, 32'h1);
        send(4'd6, 32'd5, 32'd5);
        send(4'd7, 32'h8000_0000, 32'h1);
        send(4'd7, 32'h1, 32'h8000_0000);
        send(4'hF, 32'h1234, 32'h5678);
        send(4'h3, 32'h0, 32'h0);
        send(4'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        send(4'd1, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        send(4'd12, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        for (int i = 0; i < 4; i++) send(4'($urandom_range(8, 11)), 32'h1, 32'h2);
        drain();

        // Stall: first op sits on the outputs while the second waits.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.ALUCtl = 4'd2; bus.A = 32'd10; bus.B = 32'd20;
        @(posedge clk); #1;
        bus.ALUCtl = 4'd6; bus.A = 32'd3; bus.B = 32'd9;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        send(4'd6, 32'd3, 32'd9);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(pick_ctl(), pick_operand(), pick_operand());
            if ($urandom_range(0, 5) == 0) begin
                bus.out_ready = ($urandom_range(0, 1) != 0);
                @(posedge clk); #1;
            end
        end
        rand_ready = 1'b0;
        drain();

        // Reset while a result is held under backpressure.
        bus.out_ready = 1'b0;
        send(4'hF, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drain();
        send(4'd1, 32'h1, 32'h2);
        drain();

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
